// File: rtl/twos_comp_serial_incr.sv
// Bit-serial +1 stage: adds one to a ones' complement word LSB first, one bit per clock.
// Optional final-carry port is enabled with `define TCS_CARRY_OUT_EN.
module twos_comp_serial_incr #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef TCS_CARRY_OUT_EN
    output logic             carry_out,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] shifted_s;
    logic [CNT_W-1:0] count_r;
    logic             carry_r;
    logic             sum_bit_s;
    logic             carry_step_s;
    logic             last_step_s;
    logic             accept_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] out_data_r;
`ifdef TCS_CARRY_OUT_EN
    logic             carry_out_r;
`endif

    // Serial adder step and next-state decode
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        sum_bit_s    = sr_r[0] ^ carry_r;
        carry_step_s = sr_r[0] & carry_r;
        shifted_s    = {sum_bit_s, sr_r[WIDTH-1:1]};
        last_step_s  = (count_r == CNT_W'(WIDTH - 1));
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                // Fixed latency: no early exit once the carry dies out
                if (last_step_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake/status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == DONE);
            busy_r      <= (next_state_s != IDLE);
        end
    end

    // Shift register, bit counter, carry and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_r        <= {WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            carry_r     <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
`ifdef TCS_CARRY_OUT_EN
            carry_out_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sr_r    <= in_data;
                        carry_r <= 1'b1;
                        count_r <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    sr_r    <= shifted_s;
                    carry_r <= carry_step_s;
                    count_r <= count_r + CNT_W'(1);
                    if (last_step_s) begin
                        out_data_r  <= shifted_s;
`ifdef TCS_CARRY_OUT_EN
                        carry_out_r <= carry_step_s;
`endif
                    end
                end
                DONE: begin
                    sr_r <= sr_r;
                end
                default: begin
                    sr_r <= sr_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = out_data_r;
`ifdef TCS_CARRY_OUT_EN
    assign carry_out = carry_out_r;
`endif

endmodule
